// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus frame pacer for a UART transmitter that has no busy flag:
// it pops one byte per frame slot and issues a single-cycle start pulse.
module uart_tx_feeder #(
  parameter int TicksPerBaud = 217,
  parameter int GapTicks     = 2,
  parameter int Depth        = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [7:0]                 wr_data_i,
  input  logic                       wr_valid_i,
  output logic                       wr_ready_o,
  output logic [7:0]                 tx_data_o,
  output logic                       tx_valid_o,
  output logic [$clog2(Depth):0]     level_o,
  output logic                       idle_o
);

  localparam int FrameTicks = 10 * TicksPerBaud + GapTicks;
  localparam int AW         = $clog2(Depth);
  localparam int CW         = $clog2(FrameTicks);

  localparam logic [AW:0]   FULL_CNT   = Depth[AW:0];
  localparam logic [CW-1:0] FRAME_LAST = CW'(FrameTicks - 1);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e            state_q, state_d;
  logic [7:0]        mem_q [Depth];
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_valid_q;
  logic              push, pop;

  assign push       = wr_valid_i & wr_ready_o;
  assign wr_ready_o = (count_q != FULL_CNT);
  assign level_o    = count_q;
  assign idle_o     = (state_q == IDLE) & (count_q == '0);
  assign tx_data_o  = tx_data_q;
  assign tx_valid_o = tx_valid_q;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (count_q != '0) state_d = BUSY;
      BUSY:    if (cnt_q == '0 && count_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath control: a pop starts a new frame slot
  always_comb begin
    pop       = (count_q != '0) && ((state_q == IDLE) || (cnt_q == '0));
    cnt_d     = cnt_q;
    tx_data_d = tx_data_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    if (pop) begin
      cnt_d     = FRAME_LAST;
      tx_data_d = mem_q[rd_ptr_q];
      rd_ptr_d  = rd_ptr_q + AW'(1);
    end else if (state_q == BUSY && cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      cnt_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      cnt_q      <= cnt_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= pop;
    end
  end

  // Storage needs no reset; only entries covered by count are ever read
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder with a queue/time-slot reference model
// compared every cycle, plus literal checks on pulse timing and data.
module tb_uart_tx_feeder;
  localparam int TPB = 4, GAP = 2, DEPTH = 4;
  localparam int FT  = 10 * TPB + GAP;   // 42

  logic       clk = 1'b0, rst_n = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_valid = 1'b0;
  logic       wr_ready, tx_valid, idle;
  logic [7:0] tx_data;
  logic [2:0] level;

  always #5 clk = ~clk;

  uart_tx_feeder #(.TicksPerBaud(TPB), .GapTicks(GAP), .Depth(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n), .wr_data_i(wr_data), .wr_valid_i(wr_valid),
    .wr_ready_o(wr_ready), .tx_data_o(tx_data), .tx_valid_o(tx_valid),
    .level_o(level), .idle_o(idle)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: a byte queue and a frame slot of FT cycles per pop
  int  mq[$];
  int  m_data = 0, cyc = 0, p_cyc = 0;
  bit  m_valid = 0, have_p = 0, m_pop, m_push;
  int  pl_cyc[$], pl_dat[$];

  function automatic bit m_inflight();
    return have_p && ((cyc - p_cyc) < FT);
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      mq.delete(); m_data = 0; m_valid = 0; have_p = 0;
    end else begin
      m_pop  = (mq.size() != 0) && !m_inflight();
      m_push = wr_valid && (mq.size() != DEPTH);
      m_valid = m_pop;
      if (m_pop) begin
        m_data = mq.pop_front(); have_p = 1; p_cyc = cyc;
      end
      if (m_push) mq.push_back(int'(wr_data));
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_tx_valid", int'(tx_valid), int'(m_valid));
      chk("m_tx_data",  int'(tx_data),  m_data);
      chk("m_level",    int'(level),    mq.size());
      chk("m_wr_ready", int'(wr_ready), int'(mq.size() != DEPTH));
      chk("m_idle",     int'(idle),     int'(mq.size() == 0 && !m_inflight()));
      if (tx_valid) begin
        pl_cyc.push_back(cyc);
        pl_dat.push_back(int'(tx_data));
      end
    end
  end

  task automatic push_byte(input logic [7:0] b);
    int n = 0;
    wr_data = b; wr_valid = 1'b1;
    while (!wr_ready && n < 1000) begin @(negedge clk); n++; end
    if (n >= 1000) begin
      checks++; errors++;
      $display("FAIL push_timeout got %0d expected 0", n);
    end
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic idle_n(input int n);
    wr_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!idle && n < 3000) begin @(negedge clk); n++; end
    if (n >= 3000) begin
      checks++; errors++;
      $display("FAIL idle_timeout got %0d expected 0", n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int b0, n;
    // Reset
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_tx_valid", int'(tx_valid), 0);
    chk("rst_tx_data",  int'(tx_data),  0);
    chk("rst_level",    int'(level),    0);
    chk("rst_wr_ready", int'(wr_ready), 1);
    chk("rst_idle",     int'(idle),     1);
    @(negedge clk);

    // Single byte: pulse one cycle after the write edge, idle after FT more
    push_byte(8'hA5);
    chk("single_level_peak", int'(level), 1);
    chk("single_idle_busy",  int'(idle),  0);
    chk("single_no_pulse",   int'(tx_valid), 0);
    @(negedge clk);
    chk("single_pulse",      int'(tx_valid), 1);
    chk("single_data",       int'(tx_data),  8'hA5);
    chk("single_level_after",int'(level),    0);
    @(negedge clk);
    chk("single_pulse_len",  int'(tx_valid), 0);
    repeat (40) @(negedge clk);
    chk("single_idle_41",    int'(idle), 0);
    @(negedge clk);
    chk("single_idle_42",    int'(idle), 1);

    // Burst fills the queue, producer stalls until the next pop
    b0 = pl_dat.size();
    for (int i = 1; i <= 5; i++) push_byte(8'(i));
    chk("burst_level_full", int'(level),    4);
    chk("burst_ready_low",  int'(wr_ready), 0);
    n = 0;
    while (!tx_valid && n < 100) begin
      chk("burst_stall_ready", int'(wr_ready), 0);
      @(negedge clk); n++;
    end
    chk("burst_ready_back", int'(wr_ready), 1);
    chk("burst_level_3",    int'(level),    3);
    chk("burst_second",     int'(tx_data),  2);
    push_byte(8'h06);
    wait_idle();
    chk("burst_count", pl_dat.size() - b0, 6);
    for (int i = 0; i < 6 && b0 + i < pl_dat.size(); i++) begin
      chk("burst_order", pl_dat[b0+i], i + 1);
      if (i > 0) chk("burst_spacing", pl_cyc[b0+i] - pl_cyc[b0+i-1], 42);
    end

    // Push and pop on the same edge
    push_byte(8'h30);
    push_byte(8'h31);
    chk("pp_level_1", int'(level), 1);
    idle_n(41);
    push_byte(8'h77);
    chk("pp_level_same", int'(level),    1);
    chk("pp_pulse",      int'(tx_valid), 1);
    chk("pp_data_31",    int'(tx_data),  8'h31);
    idle_n(41);
    chk("pp_gap",        int'(tx_valid), 0);
    @(negedge clk);
    chk("pp_pulse_77",   int'(tx_valid), 1);
    chk("pp_data_77",    int'(tx_data),  8'h77);
    chk("pp_level_0",    int'(level),    0);
    wait_idle();

    // Pointer wrap across several refills
    b0 = pl_dat.size();
    for (int i = 0; i < 11; i++) push_byte(8'(8'h10 + i));
    wait_idle();
    chk("wrap_count", pl_dat.size() - b0, 11);
    for (int i = 0; i < 11 && b0 + i < pl_dat.size(); i++)
      chk("wrap_order", pl_dat[b0+i], 8'h10 + i);

    // Reset mid-operation
    push_byte(8'h40);
    push_byte(8'h41);
    push_byte(8'h42);
    idle_n(9);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_tx_valid", int'(tx_valid), 0);
    chk("mrst_tx_data",  int'(tx_data),  0);
    chk("mrst_level",    int'(level),    0);
    chk("mrst_wr_ready", int'(wr_ready), 1);
    chk("mrst_idle",     int'(idle),     1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n = pl_dat.size();
    idle_n(100);
    chk("mrst_no_pulses", pl_dat.size() - n, 0);
    chk("mrst_level_end", int'(level), 0);
    chk("mrst_idle_end",  int'(idle),  1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_feeder.md
Name: uart_tx_feeder

Overview:
- Byte queue and frame pacer placed directly upstream of the static-baud UART transmitter.
- The transmitter has no ready/busy output and only accepts a byte while idle. This block buffers bytes from a valid/ready producer, such as a Wishbone peripheral register.
- It issues exactly one single-cycle tx_valid_o pulse per byte, spaced so that each pulse lands after the previous frame has completed.

Parameters:
- TicksPerBaud, 217: clock cycles per UART bit. Must equal the transmitter's value; must be >= 2.
- GapTicks, 2: extra idle cycles appended after each 10-bit frame. Must be >= 1 so the transmitter is back in idle.
- Depth, 16: queue entries. Must be a power of two, >= 2.
- Derived, not overridable: FrameTicks = 10*TicksPerBaud + GapTicks.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  reset, asynchronous assert, active-low
- wr_data_i  in  8  byte to enqueue
- wr_valid_i  in  1  producer has a byte
- wr_ready_o  out  1  queue can accept; write handshake = wr_valid_i & wr_ready_o at a rising edge
- tx_data_o  out  8  byte to transmitter; registered, holds last popped value
- tx_valid_o  out  1  single-cycle start pulse to transmitter
- level_o  out  $clog2(Depth)+1  bytes currently queued, excluding the byte in flight
- idle_o  out  1  queue empty and no frame in flight

Behaviour:
- Reset (rst_ni low, asynchronous):
  - Immediately: tx_valid_o=0, tx_data_o=0, level_o=0, wr_ready_o=1, idle_o=1.
  - Pointers and count cleared; pacer in IDLE; frame counter 0.
  - Queued bytes are discarded.
  - A reset mid-frame drops tx_valid_o at once. The transmitter's frame in progress is not this block's concern.
- Queue:
  - Circular buffer; read/write pointers $clog2(Depth) bits, wrapping modulo Depth.
  - Separate occupancy count 0..Depth.
  - wr_ready_o = (count != Depth), combinational from registered count.
  - No write bypass: a write into a full queue is impossible since ready=0, even if a pop happens in the same cycle.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - level_o = count.
- Pacer FSM, states IDLE and BUSY:
  - IDLE, count!=0: at the edge, pop head into tx_data_o, tx_valid_o<=1, cnt<=FrameTicks-1, go BUSY.
  - IDLE, count==0: stay; tx_valid_o<=0.
  - BUSY, cnt!=0: cnt<=cnt-1, tx_valid_o<=0.
  - BUSY, cnt==0, count!=0: pop and pulse as from IDLE, reload cnt<=FrameTicks-1, stay BUSY.
  - BUSY, cnt==0, count==0: go IDLE, tx_valid_o<=0.
- Frame counter width: $clog2(FrameTicks).
- tx_valid_o is high for exactly one cycle per popped byte. It is never high on two consecutive cycles.
- Latency: write handshake at edge E0 into an empty, idle block gives tx_valid_o high in the cycle after edge E1, with the byte on tx_data_o.
- Back-to-back pulses while data is queued are exactly FrameTicks cycles apart, rising edge to rising edge.
- idle_o = (state==IDLE) & (count==0), combinational from registers.
- A write arriving in the same cycle that IDLE pops an empty queue cannot occur: pop requires count!=0 before the edge. That write is seen one cycle later.

Test Plan:
- Reset check (TicksPerBaud=4, GapTicks=2, Depth=4, FrameTicks=42): hold rst_ni low, then release -> tx_valid_o=0, tx_data_o=0x00, level_o=0, wr_ready_o=1, idle_o=1.
- Single byte:
  - Stimulus: write 0xA5 at edge E0.
  - tx_valid_o high for exactly one cycle after E1 with tx_data_o=0xA5.
  - idle_o=0 until 42 cycles after the pulse, then 1.
  - level_o peaks at 1.
- Burst and full:
  - Stimulus: write 0x01..0x05 on consecutive cycles.
  - After 0x01 pops, 0x02..0x05 fill the queue: level_o=4, wr_ready_o=0, and the producer stalls.
  - Pulses carry 0x01..0x05 in order, spaced exactly 42 cycles.
  - wr_ready_o returns to 1 on the cycle after the next pop.
- Push and pop same cycle: queue holding 1 byte, write 0x77 on the cycle the pacer pops -> level_o stays 1, and 0x77 is sent 42 cycles later.
- Pointer wrap-around: send 11 bytes 0x10..0x1A across several refills -> the pointers wrap at least twice, and the output order and values match the input exactly.
- Reset mid-operation: queue 3 bytes, assert rst_ni 10 cycles after the first pulse -> outputs are at reset values before the next edge, no further tx_valid_o pulses occur, and level_o=0.
